// File: rtl/theta_apply_if.sv
// theta_apply_if: bus between theta_apply and its matrix/parity stores.
// master = driver of start/reads (store side), slave = theta_apply.
interface theta_apply_if;
  logic        start;
  logic [24:0] line_in;
  logic [4:0]  parity_in;
  logic [5:0]  cnt_value;
  logic [5:0]  parity_addr;
  logic        write_enable;
  logic [24:0] write_value;
  logic        done;
`ifdef THETA_STALL_EN
  logic        stall;

  modport master (
    output start, line_in, parity_in, stall,
    input  cnt_value, parity_addr, write_enable,
    input  write_value, done
  );

  modport slave (
    input  start, line_in, parity_in, stall,
    output cnt_value, parity_addr, write_enable,
    output write_value, done
  );
`else
  modport master (
    output start, line_in, parity_in,
    input  cnt_value, parity_addr, write_enable,
    input  write_value, done
  );

  modport slave (
    input  start, line_in, parity_in,
    output cnt_value, parity_addr, write_enable,
    output write_value, done
  );
`endif
endinterface

// File: rtl/theta_apply.sv
// theta_apply: walks 64 slices, xors each 25-bit line with the column
// parity of the current slice (x-1) and the previous slice (x+1).
// Ports: clk, rst (async, active high), bus (theta_apply_if.slave):
//   start, line_in, parity_in -> cnt_value, parity_addr,
//   write_enable, write_value, done. THETA_STALL_EN adds bus.stall.
module theta_apply (
  input  logic           clk,
  input  logic           rst,
  theta_apply_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRELOAD,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  z;
  logic [4:0]  prev_par;
  logic        done_q;
  logic        stall;
  logic        in_run;
  logic        adv;
  logic [4:0]  col;

`ifdef THETA_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  assign in_run = (state == RUN);
  assign adv    = in_run && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      z        <= 6'd0;
      prev_par <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) state <= PRELOAD;
        end
        PRELOAD: begin
          // parity_addr is 63 here, so this captures P[63]
          prev_par <= bus.parity_in;
          state    <= RUN;
        end
        RUN: begin
          if (!stall) begin
            prev_par <= bus.parity_in;
            z        <= z + 6'd1;
            if (z == 6'd63) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // col[x] = P[z][x-1] ^ P[z-1][x+1], indices mod 5
  assign col = {bus.parity_in[3:0], bus.parity_in[4]}
             ^ {prev_par[0], prev_par[4:1]};

  assign bus.cnt_value    = z;
  assign bus.parity_addr  = in_run ? z : 6'd63;
  assign bus.write_enable = adv;
  assign bus.write_value  = in_run ? (bus.line_in ^ {5{col}}) : 25'd0;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_theta_apply.sv
// tb_theta_apply: scoreboard bench for theta_apply.
// Stores are modelled as arrays read combinationally by address.
module tb_theta_apply;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  theta_apply_if bus ();

  theta_apply dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [24:0] lmem [64];
  logic [4:0]  pmem [64];

  assign bus.line_in   = lmem[bus.cnt_value];
  assign bus.parity_in = pmem[bus.parity_addr];

  typedef struct packed {
    logic [5:0]  a;
    logic [24:0] v;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;
  int   writes = 0;
  int   dones  = 0;

  function automatic logic [24:0] ref_line(
    input logic [24:0] ln,
    input logic [4:0]  cur,
    input logic [4:0]  prv
  );
    logic [24:0] r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = ln[5*y+x] ^ cur[(x+4)%5] ^ prv[(x+1)%5];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) dones++;
      if (bus.write_enable) begin
        writes++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_write addr=%0d val=%h",
                   bus.cnt_value, bus.write_value);
        end else begin
          mon_e = sb.pop_front();
          if (bus.cnt_value !== mon_e.a ||
              bus.write_value !== mon_e.v)
            $display("FAIL write got z=%0d %h want z=%0d %h",
                     bus.cnt_value, bus.write_value,
                     mon_e.a, mon_e.v);
          else passed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ref();
    for (int z = 0; z < 64; z++)
      sb.push_back({6'(z),
                    ref_line(lmem[z], pmem[z], pmem[(z+63)%64])});
  endtask

  task automatic fill_random();
    for (int z = 0; z < 64; z++) begin
      lmem[z] = 25'($urandom);
      pmem[z] = 5'($urandom);
    end
  endtask

  task automatic start_pass();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!bus.done && cyc < from + 300) begin
      step();
      cyc++;
    end
    if (!bus.done) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
`ifdef THETA_STALL_EN
    bus.stall = 1'b0;
`endif
    for (int z = 0; z < 64; z++) begin
      lmem[z] = 25'h1ffffff;
      pmem[z] = 5'h1f;
    end
    step();
    step();
    total++;
    if (bus.done !== 1'b0)
      $display("FAIL rst_done got %b want 0", bus.done);
    else passed++;
    total++;
    if (bus.write_enable !== 1'b0)
      $display("FAIL rst_we got %b want 0", bus.write_enable);
    else passed++;
    total++;
    if (bus.write_value !== 25'd0)
      $display("FAIL rst_wv got %h want 0", bus.write_value);
    else passed++;
    total++;
    if (bus.parity_addr !== 6'd63)
      $display("FAIL rst_paddr got %0d want 63", bus.parity_addr);
    else passed++;
    total++;
    if (bus.cnt_value !== 6'd0)
      $display("FAIL rst_cnt got %0d want 0", bus.cnt_value);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic check_pass(input string nm, input int cyc,
                            input int want_cyc, input int want_w,
                            input int want_d);
    total++;
    if (cyc != want_cyc)
      $display("FAIL %s_done_cycle got %0d want %0d",
               nm, cyc, want_cyc);
    else passed++;
    total++;
    if (writes != want_w || sb.size() != 0)
      $display("FAIL %s_writes got %0d left %0d want %0d",
               nm, writes, sb.size(), want_w);
    else passed++;
    total++;
    if (dones != want_d)
      $display("FAIL %s_dones got %0d want %0d", nm, dones, want_d);
    else passed++;
  endtask

  task automatic test_zero_parity();
    int cyc;
    logic [5:0] zz;
    for (int z = 0; z < 64; z++) begin
      zz = 6'(z);
      lmem[z] = {zz[4:0], 20'h0};
      pmem[z] = 5'd0;
      sb.push_back({zz, zz[4:0], 20'h0});
    end
    writes = 0;
    dones  = 0;
    start_pass();
    wait_done(1, cyc);
    step();
    check_pass("zero_par", cyc, 66, 64, 1);
  endtask

  task automatic test_single_parity();
    int cyc;
    for (int z = 0; z < 64; z++) begin
      lmem[z] = 25'd0;
      pmem[z] = 5'd0;
      if (z == 0)       sb.push_back({6'd0, 25'h1084210});
      else if (z == 63) sb.push_back({6'd63, 25'h0210842});
      else              sb.push_back({6'(z), 25'd0});
    end
    pmem[63] = 5'b00001;
    writes = 0;
    dones  = 0;
    start_pass();
    wait_done(1, cyc);
    step();
    check_pass("single_par", cyc, 66, 64, 1);
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      push_ref();
      writes = 0;
      dones  = 0;
      start_pass();
      wait_done(1, cyc);
      step();
      check_pass("random", cyc, 66, 64, 1);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    fill_random();
    push_ref();
    start_pass();
    for (int i = 1; i < 20; i++) step();
    rst = 1'b1;
    #1;
    total++;
    if (bus.write_enable !== 1'b0 || bus.write_value !== 25'd0 ||
        bus.done !== 1'b0)
      $display("FAIL midrst_out we=%b wv=%h done=%b want 0 0 0",
               bus.write_enable, bus.write_value, bus.done);
    else passed++;
    total++;
    if (bus.parity_addr !== 6'd63 || bus.cnt_value !== 6'd0)
      $display("FAIL midrst_addr paddr=%0d cnt=%0d want 63 0",
               bus.parity_addr, bus.cnt_value);
    else passed++;
    sb.delete();
    step();
    rst = 1'b0;
    step();
    fill_random();
    push_ref();
    writes = 0;
    dones  = 0;
    start_pass();
    wait_done(1, cyc);
    step();
    check_pass("midrst_pass", cyc, 66, 64, 1);
  endtask

  task automatic test_start_ignored();
    int cyc;
    fill_random();
    push_ref();
    writes = 0;
    dones  = 0;
    start_pass();
    for (int i = 1; i < 30; i++) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(31, cyc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_pass("start_ign", cyc, 66, 64, 1);
    total++;
    if (bus.write_enable !== 1'b0 || bus.parity_addr !== 6'd63)
      $display("FAIL start_ign_idle we=%b paddr=%0d want 0 63",
               bus.write_enable, bus.parity_addr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int cyc2;
    fill_random();
    push_ref();
    push_ref();
    writes = 0;
    dones  = 0;
    bus.start = 1'b1;
    step();
    wait_done(1, cyc);
    step();
    step();
    bus.start = 1'b0;
    total++;
    if (bus.write_enable !== 1'b0 || bus.parity_addr !== 6'd63)
      $display("FAIL b2b_preload we=%b paddr=%0d want 0 63",
               bus.write_enable, bus.parity_addr);
    else passed++;
    total++;
    if (cyc != 66)
      $display("FAIL b2b_first_done got %0d want 66", cyc);
    else passed++;
    wait_done(68, cyc2);
    step();
    check_pass("b2b", cyc2, 133, 128, 2);
  endtask

`ifdef THETA_STALL_EN
  task automatic test_stall();
    int cyc;
    fill_random();
    push_ref();
    writes = 0;
    dones  = 0;
    start_pass();
    for (int i = 1; i < 12; i++) step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.write_enable !== 1'b0 || bus.cnt_value !== 6'd10)
        $display("FAIL stall_hold we=%b cnt=%0d want 0 10",
                 bus.write_enable, bus.cnt_value);
      else passed++;
      step();
    end
    bus.stall = 1'b0;
    wait_done(15, cyc);
    step();
    check_pass("stall", cyc, 69, 64, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_parity();
    test_single_parity();
    test_random();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
`ifdef THETA_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
